// File: rtl/cpu_pkg.sv
// Shared definitions for the simple CPU sequencer: opcodes, ALU encodings,
// sequencer states and instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;
    localparam logic [2:0] ALU_NOT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    // Opcodes 0x8..0xD are unassigned; they execute as NOP but flag the program.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'h8) && (op <= 4'hD);
    endfunction

endpackage

// File: rtl/control_unit.sv
// Opcode decoder: maps a 4-bit opcode onto the ALU operation and the
// register write enable. Anything outside the arithmetic group is a no-write ADD.
module control_unit
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] alu_op,
    output logic       reg_write
);

    always_comb begin
        alu_op    = ALU_ADD;
        reg_write = 1'b0;
        case (opcode)
            OP_ADD: begin alu_op = ALU_ADD; reg_write = 1'b1; end
            OP_SUB: begin alu_op = ALU_SUB; reg_write = 1'b1; end
            OP_AND: begin alu_op = ALU_AND; reg_write = 1'b1; end
            OP_OR:  begin alu_op = ALU_OR;  reg_write = 1'b1; end
            OP_XOR: begin alu_op = ALU_XOR; reg_write = 1'b1; end
            OP_SHL: begin alu_op = ALU_SHL; reg_write = 1'b1; end
            OP_SHR: begin alu_op = ALU_SHR; reg_write = 1'b1; end
            OP_NOT: begin alu_op = ALU_NOT; reg_write = 1'b1; end
            default: begin alu_op = ALU_ADD; reg_write = 1'b0; end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/writeback controller: fetches one instruction at a time
// over a req/valid handshake and drives the ALU/register-file control lines.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH     = 8,
    parameter int RETIRE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    imem_req,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic                    imem_valid,
    input  logic [15:0]             imem_rdata,
    output logic [3:0]              rf_raddr_a,
    output logic [3:0]              rf_raddr_b,
    output logic [2:0]              alu_op,
    output logic                    rf_we,
    output logic [3:0]              rf_waddr,
    output logic                    busy,
    output logic                    halted,
    output logic                    illegal,
    output logic [RETIRE_WIDTH-1:0] retired
);

    state_t                  state_reg, state_next;
    logic [PC_WIDTH-1:0]     pc_reg;
    logic [15:0]             ir_reg;
    logic [2:0]              alu_op_reg;
    logic [3:0]              raddr_a_reg, raddr_b_reg, waddr_reg;
    logic                    we_flag_reg, ill_flag_reg, illegal_reg;
    logic [RETIRE_WIDTH-1:0] retired_reg;

    logic [3:0] opcode;
    logic [2:0] dec_alu_op;
    logic       dec_we;

    assign opcode = ir_reg[OPC_MSB:OPC_LSB];

    control_unit u_control_unit (
        .opcode    (opcode),
        .alu_op    (dec_alu_op),
        .reg_write (dec_we)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_HALT: if (start) state_next = ST_FETCH;
            ST_FETCH:         if (imem_valid) state_next = ST_DECODE;
            ST_DECODE:        state_next = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
            ST_EXEC:          state_next = ST_WB;
            ST_WB:            state_next = ST_FETCH;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= '0;
            ir_reg       <= '0;
            alu_op_reg   <= ALU_ADD;
            raddr_a_reg  <= '0;
            raddr_b_reg  <= '0;
            waddr_reg    <= '0;
            we_flag_reg  <= 1'b0;
            ill_flag_reg <= 1'b0;
            illegal_reg  <= 1'b0;
            retired_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc_reg      <= '0;
                        illegal_reg <= 1'b0;
                        retired_reg <= '0;
                    end
                end
                ST_FETCH: begin
                    if (imem_valid) ir_reg <= imem_rdata;
                end
                ST_DECODE: begin
                    alu_op_reg   <= dec_alu_op;
                    raddr_a_reg  <= ir_reg[RS1_MSB:RS1_LSB];
                    raddr_b_reg  <= ir_reg[RS2_MSB:RS2_LSB];
                    waddr_reg    <= ir_reg[RD_MSB:RD_LSB];
                    we_flag_reg  <= dec_we;
                    ill_flag_reg <= is_illegal_op(opcode);
                end
                ST_WB: begin
                    // PC wraps naturally; the retire count sticks at all-ones.
                    pc_reg <= pc_reg + PC_WIDTH'(1);
                    if (ill_flag_reg) illegal_reg <= 1'b1;
                    if (retired_reg != '1) retired_reg <= retired_reg + RETIRE_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign imem_req   = (state_reg == ST_FETCH);
    assign imem_addr  = pc_reg;
    assign rf_raddr_a = raddr_a_reg;
    assign rf_raddr_b = raddr_b_reg;
    assign rf_waddr   = waddr_reg;
    assign alu_op     = alu_op_reg;
    assign rf_we      = (state_reg == ST_WB) && we_flag_reg;
    assign busy       = (state_reg == ST_FETCH) || (state_reg == ST_DECODE) ||
                        (state_reg == ST_EXEC)  || (state_reg == ST_WB);
    assign halted     = (state_reg == ST_HALT);
    assign illegal    = illegal_reg;
    assign retired    = retired_reg;

endmodule
